// File: rtl/bounce_generator.sv
// Push-button bounce emulator: turns a clean level into a bouncy one.
// Each accepted change emits an LFSR-driven toggle burst, then a settle window.
module bounce_generator #(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en_bounce,
    input  logic       boton_ideal,
    output logic       boton_rebote,
    output logic       busy,
    output logic [7:0] edges_emitted
);

    // An all-zero seed would lock the LFSR, so it is promoted to 01.
    localparam logic [7:0] SEED =
        (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] LFSR_MASK   = 8'hB8;
    localparam logic [7:0] BOUNCE_LOAD = 8'(BOUNCE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       level_q;
    logic       level_d;
    logic       target_q;
    logic       target_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       rebote_q;
    logic       rebote_d;
    logic       busy_q;
    logic       busy_d;
    logic [7:0] edges_q;
    logic [7:0] edges_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    // State and datapath registers; clr wins over every other update.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            level_q  <= 1'b0;
            target_q <= 1'b0;
            cnt_q    <= 8'd0;
            lfsr_q   <= SEED;
            rebote_q <= 1'b0;
            busy_q   <= 1'b0;
            edges_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            rebote_q <= rebote_d;
            busy_q   <= busy_d;
            edges_q  <= edges_d;
        end
    end

    // Next-state logic: accept changes in IDLE, toggle in BOUNCE, hold in SETTLE.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_step(lfsr_q);
        rebote_d = rebote_q;
        busy_d   = busy_q;
        edges_d  = edges_q;

        unique case (state_q)
            IDLE: begin
                if (boton_ideal != level_q) begin
                    if (en_bounce) begin
                        target_d = boton_ideal;
                        rebote_d = boton_ideal;
                        edges_d  = 8'd1;
                        busy_d   = 1'b1;
                        cnt_d    = BOUNCE_LOAD;
                        state_d  = BOUNCE;
                    end else begin
                        level_d  = boton_ideal;
                        rebote_d = boton_ideal;
                    end
                end
            end
            BOUNCE: begin
                if (cnt_q == 8'd0) begin
                    rebote_d = target_q;
                    if (rebote_q != target_q) begin
                        edges_d = sat_inc(edges_q);
                    end
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (lfsr_q[0]) begin
                        rebote_d = ~rebote_q;
                        edges_d  = sat_inc(edges_q);
                    end
                end
            end
            SETTLE: begin
                rebote_d = target_q;
                if (cnt_q == 8'd0) begin
                    level_d = target_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign boton_rebote  = rebote_q;
    assign busy          = busy_q;
    assign edges_emitted = edges_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Scoreboard bench for bounce_generator with an LFSR burst model
// and a 3-stage debouncer loopback.
module tb_bounce_generator;

    localparam int         B    = 16;
    localparam int         S    = 8;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         NB   = B + S + 1;
    localparam int         NG   = 1000;

    logic       clk = 1'b0;
    logic       clr;
    logic       en_bounce;
    logic       boton_ideal;
    logic       boton_rebote;
    logic       busy;
    logic [7:0] edges_emitted;

    always #5 clk = ~clk;

    bounce_generator #(
        .BOUNCE_CYCLES(B),
        .SETTLE_CYCLES(S),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .clr(clr),
        .en_bounce(en_bounce),
        .boton_ideal(boton_ideal),
        .boton_rebote(boton_rebote),
        .busy(busy),
        .edges_emitted(edges_emitted)
    );

    typedef struct {
        logic       reb;
        logic       bsy;
        logic [7:0] edg;
        bit         last;
        int         tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t plan[$];

    int n_chk  = 0;
    int n_pass = 0;

    bit cnt_en     = 1'b0;
    bit final_req  = 1'b0;
    bit final_done = 1'b0;

    logic [7:0] m_lfsr;
    logic [7:0] e_last;

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reference LFSR, free-running like the generator's.
    always @(posedge clk) m_lfsr <= clr ? SEED : lstep(m_lfsr);

    // Debouncer fed by the DUT output.
    bit [2:0] sr_d = 3'b000;
    bit       db_d = 1'b0;
    int       rise_d = 0;
    int       fall_d = 0;

    always @(posedge clk) begin
        sr_d <= {sr_d[1:0], boton_rebote};
        if ({sr_d[1:0], boton_rebote} === 3'b111 && !db_d) begin
            db_d <= 1'b1;
            if (cnt_en) rise_d <= rise_d + 1;
        end else if ({sr_d[1:0], boton_rebote} === 3'b000 && db_d) begin
            db_d <= 1'b0;
            if (cnt_en) fall_d <= fall_d + 1;
        end
    end

    // Monitor: pops one expectation per clock and compares.
    exp_t     x;
    bit [2:0] sr_m = 3'b000;
    bit       db_m = 1'b0;
    int       rise_m = 0;
    int       fall_m = 0;

    task automatic check(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", nm, got, want);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            n_chk++;
            if (boton_rebote === x.reb && busy === x.bsy &&
                edges_emitted === x.edg) begin
                n_pass++;
            end else begin
                $display("FAIL out tag=%0d got reb=%b busy=%b edges=%0d want reb=%b busy=%b edges=%0d",
                         x.tag, boton_rebote, busy, edges_emitted,
                         x.reb, x.bsy, x.edg);
            end
            if ({sr_m[1:0], x.reb} === 3'b111 && !db_m) begin
                db_m = 1'b1;
                if (cnt_en) rise_m++;
            end else if ({sr_m[1:0], x.reb} === 3'b000 && db_m) begin
                db_m = 1'b0;
                if (cnt_en) fall_m++;
            end
            sr_m = {sr_m[1:0], x.reb};
            if (x.last) begin
                check($sformatf("db_settled tag=%0d", x.tag),
                      int'(db_d), int'(x.reb));
                check($sformatf("parity tag=%0d", x.tag),
                      int'(edges_emitted[0]), 1);
            end
        end else if (final_req && !final_done) begin
            check("db_rise_vs_model", rise_d, rise_m);
            check("db_fall_vs_model", fall_d, fall_m);
            check("db_rise_vs_fall", rise_d, fall_d);
            final_done = 1'b1;
        end
    end

    task automatic cyc(input logic r, input logic b,
                       input logic [7:0] e, input int tag);
        exp_t y;
        y = '{r, b, e, 1'b0, tag};
        sb_q.push_back(y);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r,
                        input logic [7:0] e, input int tag);
        for (int i = 0; i < n; i++) cyc(r, 1'b0, e, tag);
    endtask

    // Expected burst, from the model LFSR value just before edge k.
    task automatic build(input logic tgt, input int tag);
        logic [7:0] l;
        logic [7:0] e;
        logic       cur;
        exp_t       y;
        plan.delete();
        l   = m_lfsr;
        cur = tgt;
        e   = 8'd1;
        y = '{tgt, 1'b1, e, 1'b0, tag};
        plan.push_back(y);
        l = lstep(l);
        for (int j = 1; j < B; j++) begin
            if (l[0]) begin
                cur = ~cur;
                e   = sat(e);
            end
            y = '{cur, 1'b1, e, 1'b0, tag};
            plan.push_back(y);
            l = lstep(l);
        end
        if (cur != tgt) e = sat(e);
        y = '{tgt, 1'b1, e, 1'b0, tag};
        plan.push_back(y);
        for (int j = 1; j < S; j++) plan.push_back(y);
        y = '{tgt, 1'b0, e, 1'b1, tag};
        plan.push_back(y);
        e_last = e;
    endtask

    // Play n plan steps; inside [g0,g1] the input glitches and en drops.
    task automatic run(input logic tgt, input int n,
                       input int g0, input int g1);
        for (int i = 0; i < n; i++) begin
            if (i >= g0 && i <= g1) begin
                boton_ideal = ~tgt;
                en_bounce   = 1'b0;
            end else begin
                boton_ideal = tgt;
                en_bounce   = 1'b1;
            end
            sb_q.push_back(plan[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        clr         = 1'b1;
        en_bounce   = 1'b1;
        boton_ideal = 1'b1;
        cyc(1'b0, 1'b0, 8'd0, 1);
        cyc(1'b0, 1'b0, 8'd0, 1);
        clr = 1'b0;
        build(1'b1, 2);
        run(1'b1, NB, NG, NG);
        idle(3, 1'b1, 8'd7, 3);

        en_bounce   = 1'b0;
        boton_ideal = 1'b0;
        cyc(1'b0, 1'b0, 8'd7, 4);
        idle(4, 1'b0, 8'd7, 4);
        boton_ideal = 1'b1;
        cyc(1'b1, 1'b0, 8'd7, 5);
        idle(4, 1'b1, 8'd7, 5);
        boton_ideal = 1'b0;
        cyc(1'b0, 1'b0, 8'd7, 6);
        idle(4, 1'b0, 8'd7, 6);

        boton_ideal = 1'b1;
        en_bounce   = 1'b1;
        build(1'b1, 7);
        run(1'b1, NB, 3, 5);
        idle(4, 1'b1, e_last, 8);

        boton_ideal = 1'b0;
        build(1'b0, 9);
        run(1'b0, NB, NG, NG);
        idle(3, 1'b0, e_last, 10);

        boton_ideal = 1'b1;
        build(1'b1, 11);
        run(1'b1, 5, NG, NG);
        clr = 1'b1;
        cyc(1'b0, 1'b0, 8'd0, 12);
        clr = 1'b0;
        build(1'b1, 13);
        run(1'b1, NB, NG, NG);
        idle(3, 1'b1, 8'd7, 14);

        boton_ideal = 1'b0;
        build(1'b0, 15);
        run(1'b0, NB, NG, NG);
        idle(4, 1'b0, e_last, 16);

        cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            boton_ideal = 1'b1;
            build(1'b1, 20 + 2 * i);
            run(1'b1, NB, NG, NG);
            idle(2, 1'b1, e_last, 20 + 2 * i);
            boton_ideal = 1'b0;
            build(1'b0, 21 + 2 * i);
            run(1'b0, NB, NG, NG);
            idle(2, 1'b0, e_last, 21 + 2 * i);
        end
        idle(4, 1'b0, e_last, 40);
        cnt_en = 1'b0;
        idle(1, 1'b0, e_last, 41);

        final_req = 1'b1;
        for (int t = 0; t < 20 && !final_done; t++) @(negedge clk);
        if (!final_done) begin
            $display("FAIL final_wait got=0 want=1");
            $fatal(1, "final checks never ran");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Synthesizable push-button bounce emulator: the transmitting end of the button/debounce interface.
- Takes a clean button level and emits a bouncy version. Each level change is followed by a pseudo-random toggle burst, then a stable settle window.
- Used for on-FPGA self-test of the shift-register debouncer and as a stimulus source in benches; output connects directly to the debouncer's button input.

Parameters:
- BOUNCE_CYCLES, 16, length of the random-toggle window in clk cycles; legal range 2..255.
- SETTLE_CYCLES, 8, cycles the target level is held stable before a new change is accepted; legal range 1..255.
- LFSR_SEED, 8'hA5, LFSR value loaded at reset; 8'h00 is replaced by 8'h01.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, synchronous, active-high.
- en_bounce  input  1  1 = emulate bounce; 0 = clean pass-through.
- boton_ideal  input  1  clean button level requested.
- boton_rebote  output  1  registered bouncy button level to the debouncer.
- busy  output  1  high while in BOUNCE or SETTLE.
- edges_emitted  output  8  transitions of boton_rebote during the current/last burst, saturating at 255.

Behaviour:
- Reset (clr=1 at a rising edge) has priority over everything and takes effect regardless of state. Next cycle values:
  - boton_rebote=0, busy=0, edges_emitted=0.
  - State=IDLE, held level=0, target=0, counter=0, lfsr=LFSR_SEED (01 if seed=00).
- LFSR:
  - 8-bit Galois, mask 8'hB8.
  - Each edge: if lfsr[0], lfsr <= (lfsr>>1)^8'hB8, else lfsr <= lfsr>>1.
  - Advances every non-reset edge in every state.
  - Never reaches 00.
- States: IDLE, BOUNCE, SETTLE.
- IDLE:
  - boton_rebote holds the current level.
  - If boton_ideal == level: no action.
  - If boton_ideal != level and en_bounce=0: level and boton_rebote <= boton_ideal on the same edge (1-cycle latency). busy stays 0; edges_emitted is unchanged.
  - If boton_ideal != level and en_bounce=1, at edge k:
    - target <= boton_ideal; boton_rebote <= boton_ideal; edges_emitted <= 1.
    - busy <= 1; counter <= BOUNCE_CYCLES-1; state <= BOUNCE.
- BOUNCE, edges k+1 .. k+BOUNCE_CYCLES-1:
  - If the current lfsr[0]=1 (value before this edge's update), boton_rebote toggles and edges_emitted increments (saturating). Otherwise it holds.
  - counter decrements each edge.
- BOUNCE exit, edge k+BOUNCE_CYCLES:
  - boton_rebote <= target, counting one edge if this changes the value.
  - counter <= SETTLE_CYCLES-1; state <= SETTLE.
- SETTLE:
  - boton_rebote is held at target; counter decrements.
  - At edge k+BOUNCE_CYCLES+SETTLE_CYCLES: level <= target, busy <= 0, state <= IDLE.
  - busy is therefore high for exactly BOUNCE_CYCLES+SETTLE_CYCLES cycles.
- boton_ideal is ignored while busy, including en_bounce changes. The target latched at entry is always delivered.
- After returning to IDLE, a boton_ideal that differs from level starts a new burst on the next edge. No change is lost, but intermediate glitches on boton_ideal shorter than busy are dropped.
- Invariant: the final edges_emitted parity is odd (net one level change), up to saturation.
- Timing guarantee: boton_rebote is stable for SETTLE_CYCLES ≥ 3, so a 3-stage debouncer resolves the change within the settle window.
- edges_emitted holds its last value in IDLE and clears only at burst entry or reset.

Test Plan:
- Reset: drive clr=1 for 2 cycles with boton_ideal=1 -> boton_rebote=0, busy=0, edges_emitted=0. First post-reset edge starts a burst toward 1.
- Pass-through: en_bounce=0, toggle boton_ideal 0→1→0 with 5-cycle spacing -> boton_rebote follows with 1-cycle latency; busy stays 0.
- Press burst (defaults, seed A5): boton_ideal 0→1 sampled at edge k.
  - boton_rebote=1 after edge k; busy high for 24 cycles.
  - boton_rebote=1 constantly from edge k+16 through k+24.
  - edges_emitted odd, and equal to the bit-exact LFSR model's count and toggle sequence.
- Ignore-while-busy: pulse boton_ideal 1→0→1 during BOUNCE -> burst completes to 1; no second burst; busy falls at k+24.
- Release and reset mid-burst:
  - Release after idle -> new burst ending at 0 with odd edges_emitted.
  - clr=1 at edge k+5 -> next cycle boton_rebote=0, busy=0, state IDLE, lfsr reloaded.
- Debouncer loopback: boton_rebote into the 3-stage debouncer, 10 press/release cycles -> the debouncer output shows exactly 10 rising and 10 falling edges. Each settles before busy falls.
